// File: rtl/lcd_byte_sequencer.sv
// rtl/lcd_byte_sequencer.sv - writes one byte to a 4-bit LCD bus as two timed nibble strobes
module lcd_byte_sequencer #(
    parameter int T_SETUP    = 2,
    parameter int T_EN       = 12,
    parameter int T_HOLD     = 1,
    parameter int T_NIB_GAP  = 50,
    parameter int T_BYTE_GAP = 2000,
    parameter int T_LONG_GAP = 82000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_rs,
    input  logic [7:0] req_byte,
    input  logic       req_long,
    output logic       done,
    output logic       LCD_RS,
    output logic       LCD_RW,
    output logic       LCD_EN,
    output logic [3:0] LCD_SF_D
);

    // Counter is sized for the longest phase so any parameter set fits.
    localparam int MAX_A = (T_SETUP > T_EN) ? T_SETUP : T_EN;
    localparam int MAX_B = (MAX_A > T_HOLD) ? MAX_A : T_HOLD;
    localparam int MAX_C = (MAX_B > T_NIB_GAP) ? MAX_B : T_NIB_GAP;
    localparam int MAX_D = (MAX_C > T_BYTE_GAP) ? MAX_C : T_BYTE_GAP;
    localparam int MAX_P = (MAX_D > T_LONG_GAP) ? MAX_D : T_LONG_GAP;
    localparam int CNT_W = $clog2(MAX_P + 1);

    // Each phase loads (length - 1) and advances when the counter reaches zero.
    localparam logic [CNT_W-1:0] L_SETUP = CNT_W'(T_SETUP - 1);
    localparam logic [CNT_W-1:0] L_EN    = CNT_W'(T_EN - 1);
    localparam logic [CNT_W-1:0] L_HOLD  = CNT_W'(T_HOLD - 1);
    localparam logic [CNT_W-1:0] L_NIB   = CNT_W'(T_NIB_GAP - 1);
    localparam logic [CNT_W-1:0] L_BYTE  = CNT_W'(T_BYTE_GAP - 1);
    localparam logic [CNT_W-1:0] L_LONG  = CNT_W'(T_LONG_GAP - 1);

    typedef enum logic [3:0] {
        IDLE,
        HI_SETUP,
        HI_EN,
        HI_HOLD,
        NIB_GAP,
        LO_SETUP,
        LO_EN,
        LO_HOLD,
        BYTE_GAP
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [3:0]       lo_nib;
    logic             long_gap;

    // The bus is write-only; ready is masked while reset is held.
    assign LCD_RW    = 1'b0;
    assign req_ready = (state == IDLE) && !reset;

    // Sequencer: outputs are set on the edge that enters each phase so they are registered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            lo_nib   <= 4'h0;
            long_gap <= 1'b0;
            done     <= 1'b0;
            LCD_RS   <= 1'b0;
            LCD_EN   <= 1'b0;
            LCD_SF_D <= 4'h0;
        end else begin
            done <= 1'b0;
            if (state == IDLE) begin
                if (req_valid) begin
                    state    <= HI_SETUP;
                    cnt      <= L_SETUP;
                    LCD_RS   <= req_rs;
                    LCD_SF_D <= req_byte[7:4];
                    lo_nib   <= req_byte[3:0];
                    long_gap <= req_long;
                end
            end else if (cnt != '0) begin
                cnt <= cnt - CNT_W'(1);
            end else begin
                case (state)
                    HI_SETUP: begin
                        state  <= HI_EN;
                        cnt    <= L_EN;
                        LCD_EN <= 1'b1;
                    end
                    HI_EN: begin
                        state  <= HI_HOLD;
                        cnt    <= L_HOLD;
                        LCD_EN <= 1'b0;
                    end
                    HI_HOLD: begin
                        state <= NIB_GAP;
                        cnt   <= L_NIB;
                    end
                    NIB_GAP: begin
                        state    <= LO_SETUP;
                        cnt      <= L_SETUP;
                        LCD_SF_D <= lo_nib;
                    end
                    LO_SETUP: begin
                        state  <= LO_EN;
                        cnt    <= L_EN;
                        LCD_EN <= 1'b1;
                    end
                    LO_EN: begin
                        state  <= LO_HOLD;
                        cnt    <= L_HOLD;
                        LCD_EN <= 1'b0;
                    end
                    LO_HOLD: begin
                        state <= BYTE_GAP;
                        cnt   <= long_gap ? L_LONG : L_BYTE;
                    end
                    BYTE_GAP: begin
                        state <= IDLE;
                        done  <= 1'b1;
                    end
                    default: begin
                        state  <= IDLE;
                        LCD_EN <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_lcd_byte_sequencer.sv
// tb/tb_lcd_byte_sequencer.sv - directed self-checking bench for lcd_byte_sequencer
module tb_lcd_byte_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       req_valid;
    logic       req_ready;
    logic       req_rs;
    logic [7:0] req_byte;
    logic       req_long;
    logic       done;
    logic       LCD_RS;
    logic       LCD_RW;
    logic       LCD_EN;
    logic [3:0] LCD_SF_D;

    lcd_byte_sequencer dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_rs    (req_rs),
        .req_byte  (req_byte),
        .req_long  (req_long),
        .done      (done),
        .LCD_RS    (LCD_RS),
        .LCD_RW    (LCD_RW),
        .LCD_EN    (LCD_EN),
        .LCD_SF_D  (LCD_SF_D)
    );

    always #10 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    int acc_q[$];
    int rise_q[$];
    int fall_q[$];
    int done_q[$];
    int rdy_q[$];
    logic [4:0] risd_q[$];

    logic       en_prev;
    logic       done_prev;
    logic       rdy_prev;
    logic [4:0] hist1;
    logic [4:0] hist2;
    logic [4:0] rise_d;
    int         rise_t;
    int         k_c;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic resync();
        en_prev   = LCD_EN;
        done_prev = done;
        rdy_prev  = req_ready;
        hist1     = {LCD_RS, LCD_SF_D};
        hist2     = {LCD_RS, LCD_SF_D};
    endtask

    task automatic clear_q();
        acc_q.delete();
        rise_q.delete();
        fall_q.delete();
        done_q.delete();
        rdy_q.delete();
        risd_q.delete();
    endtask

    // One clock: note acceptance, then sample 1 ns after the edge and run the bus-timing monitor.
    task automatic step();
        logic       acc;
        logic [4:0] cur;
        acc = req_valid && req_ready;
        @(posedge clk);
        #1;
        cyc++;
        if (acc) acc_q.push_back(cyc);
        cur = {LCD_RS, LCD_SF_D};
        chk("rw_zero", {31'd0, LCD_RW}, 32'd0);
        if (done && done_prev) chk("done_double", {31'd0, done_prev}, 32'd0);
        if (LCD_EN && !en_prev) begin
            rise_q.push_back(cyc);
            risd_q.push_back(cur);
            chk("setup_stable_1", {27'd0, hist1}, {27'd0, cur});
            chk("setup_stable_2", {27'd0, hist2}, {27'd0, cur});
            rise_d = cur;
            rise_t = cyc;
        end else if (LCD_EN) begin
            if (cur !== rise_d) chk("en_stable", {27'd0, cur}, {27'd0, rise_d});
        end else if (en_prev) begin
            fall_q.push_back(cyc);
            chk("hold_stable", {27'd0, cur}, {27'd0, rise_d});
            chk("en_width", cyc - rise_t, 32'd12);
        end
        if (done) done_q.push_back(cyc);
        if (req_ready && !rdy_prev) rdy_q.push_back(cyc);
        hist2     = hist1;
        hist1     = cur;
        en_prev   = LCD_EN;
        done_prev = done;
        rdy_prev  = req_ready;
    endtask

    initial begin
        reset     = 1'b1;
        req_valid = 1'b0;
        req_rs    = 1'b0;
        req_byte  = 8'h00;
        req_long  = 1'b0;

        // Reset state
        #5;
        chk("rst_ready", {31'd0, req_ready}, 32'd0);
        chk("rst_en", {31'd0, LCD_EN}, 32'd0);
        chk("rst_rs", {31'd0, LCD_RS}, 32'd0);
        chk("rst_sfd", {28'd0, LCD_SF_D}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_rw", {31'd0, LCD_RW}, 32'd0);
        #196;
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("ready_after_rst", {31'd0, req_ready}, 32'd1);
        resync();
        cyc = 0;

        // Three back-to-back bytes, req_byte/req_rs scrambled every cycle after the first accept
        req_valid = 1'b1;
        req_byte  = 8'h41;
        req_rs    = 1'b1;
        req_long  = 1'b0;
        while (cyc < 6250) begin
            step();
            req_valid = (cyc + 1 <= 4163);
            req_byte  = 8'((cyc + 1) * 37 + 5);
            req_rs    = 1'((cyc + 1) % 2);
        end
        chk("bb_acc_n", acc_q.size(), 32'd3);
        chk("bb_acc0", acc_q[0], 32'd1);
        chk("bb_acc1", acc_q[1], 32'd2082);
        chk("bb_acc2", acc_q[2], 32'd4163);
        chk("bb_rise_n", rise_q.size(), 32'd6);
        chk("bb_fall_n", fall_q.size(), 32'd6);
        chk("b0_hi_rise", rise_q[0], 32'd3);
        chk("b0_hi_fall", fall_q[0], 32'd15);
        chk("b0_lo_rise", rise_q[1], 32'd68);
        chk("b0_lo_fall", fall_q[1], 32'd80);
        chk("b1_hi_rise", rise_q[2], 32'd2084);
        chk("b1_lo_fall", fall_q[3], 32'd2161);
        chk("b2_hi_rise", rise_q[4], 32'd4165);
        chk("b2_lo_fall", fall_q[5], 32'd4242);
        chk("b0_hi_data", {27'd0, risd_q[0]}, 32'h14);
        chk("b0_lo_data", {27'd0, risd_q[1]}, 32'h11);
        chk("b1_hi_data", {27'd0, risd_q[2]}, 32'h0E);
        chk("b1_lo_data", {27'd0, risd_q[3]}, 32'h0F);
        chk("b2_hi_data", {27'd0, risd_q[4]}, 32'h1B);
        chk("b2_lo_data", {27'd0, risd_q[5]}, 32'h14);
        chk("bb_done_n", done_q.size(), 32'd3);
        chk("bb_done0", done_q[0], 32'd2081);
        chk("bb_done1", done_q[1], 32'd4162);
        chk("bb_done2", done_q[2], 32'd6243);
        chk("bb_rdy_n", rdy_q.size(), 32'd3);
        chk("bb_rdy0", rdy_q[0], 32'd2081);
        chk("bb_rdy2", rdy_q[2], 32'd6243);

        // Long-gap command 0x01, inputs disturbed right after acceptance
        clear_q();
        req_valid = 1'b1;
        req_byte  = 8'h01;
        req_rs    = 1'b0;
        req_long  = 1'b1;
        step();
        req_valid = 1'b0;
        req_byte  = 8'hFF;
        req_rs    = 1'b1;
        req_long  = 1'b0;
        while (cyc < 6251 + 82085) step();
        chk("lg_acc_n", acc_q.size(), 32'd1);
        chk("lg_acc", acc_q[0], 32'd6251);
        chk("lg_rise_n", rise_q.size(), 32'd2);
        chk("lg_hi_rise", rise_q[0], 32'd6253);
        chk("lg_lo_rise", rise_q[1], 32'd6318);
        chk("lg_lo_fall", fall_q[1], 32'd6330);
        chk("lg_hi_data", {27'd0, risd_q[0]}, 32'h00);
        chk("lg_lo_data", {27'd0, risd_q[1]}, 32'h01);
        chk("lg_rdy_n", rdy_q.size(), 32'd1);
        chk("lg_rdy", rdy_q[0], 32'd88331);
        chk("lg_done_n", done_q.size(), 32'd1);
        chk("lg_done", done_q[0], 32'd88331);
        chk("lg_rs_idle", {31'd0, LCD_RS}, 32'd0);

        // Reset during the lower-nibble strobe
        clear_q();
        req_valid = 1'b1;
        req_byte  = 8'h5A;
        req_rs    = 1'b1;
        req_long  = 1'b0;
        step();
        k_c       = cyc;
        req_valid = 1'b0;
        while (cyc < k_c + 70) step();
        chk("mid_en", {31'd0, LCD_EN}, 32'd1);
        chk("mid_sfd", {28'd0, LCD_SF_D}, 32'hA);
        chk("mid_rs", {31'd0, LCD_RS}, 32'd1);
        #4;
        reset = 1'b1;
        #1;
        chk("arst_en", {31'd0, LCD_EN}, 32'd0);
        chk("arst_sfd", {28'd0, LCD_SF_D}, 32'd0);
        chk("arst_rs", {31'd0, LCD_RS}, 32'd0);
        chk("arst_ready", {31'd0, req_ready}, 32'd0);
        @(posedge clk);
        #1;
        chk("arst_ready_held", {31'd0, req_ready}, 32'd0);
        chk("arst_done", {31'd0, done}, 32'd0);
        reset = 1'b0;
        resync();
        clear_q();
        step();
        chk("arst_ready_rel", {31'd0, req_ready}, 32'd1);
        repeat (200) step();
        chk("arst_no_rise", rise_q.size(), 32'd0);
        chk("arst_no_done", done_q.size(), 32'd0);
        chk("arst_no_acc", acc_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
